// File: rtl/board_draw_scheduler.sv
// Redraw sequencer for the 4x4 sliding-puzzle board: raster-fills each tile,
// then lends the plotter to the shared digit-glyph drawer at that tile's origin.
module board_draw_scheduler #(
    parameter logic [7:0]  ORIGIN_X     = 8'd16,
    parameter logic [6:0]  ORIGIN_Y     = 7'd0,
    parameter int unsigned TILE_SIZE    = 30,
    parameter int unsigned GLYPH_CYCLES = 121,
    parameter logic [2:0]  TILE_COLOUR  = 3'b111,
    parameter logic [2:0]  BG_COLOUR    = 3'b000,
    parameter logic [2:0]  DIGIT_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] board,
    input  logic [7:0]  glyph_x,
    input  logic [6:0]  glyph_y,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tile_x,
    output logic [6:0]  tile_y,
    output logic [3:0]  digit,
    output logic        glyph_clear,
    output logic        glyph_enable,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);

    localparam int unsigned FW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam int unsigned GW = (GLYPH_CYCLES > 1) ? $clog2(GLYPH_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FILL, S_GCLR, S_GLYPH, S_NEXT, S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [63:0]    r_board;
    logic [3:0]     r_tile;
    logic [FW-1:0]  r_fx;
    logic [FW-1:0]  r_fy;
    logic [GW-1:0]  r_gcnt;

    logic [3:0]     w_digit;
    logic [7:0]     w_tile_x;
    logic [6:0]     w_tile_y;
    logic [7:0]     w_fill_x;
    logic [6:0]     w_fill_y;
    logic           w_fill_last;
    logic           w_glyph_last;
    logic           w_geom_valid;

    // Tile geometry from the latched board and the current tile index
    assign w_digit      = r_board[{r_tile, 2'b00} +: 4];
    assign w_tile_x     = 8'(32'(ORIGIN_X) + 32'(r_tile[1:0]) * TILE_SIZE);
    assign w_tile_y     = 7'(32'(ORIGIN_Y) + 32'(r_tile[3:2]) * TILE_SIZE);
    assign w_fill_x     = 8'(32'(w_tile_x) + 32'(r_fx));
    assign w_fill_y     = 7'(32'(w_tile_y) + 32'(r_fy));
    assign w_fill_last  = (r_fx == FW'(TILE_SIZE - 1)) && (r_fy == FW'(TILE_SIZE - 1));
    assign w_glyph_last = (r_gcnt == GW'(GLYPH_CYCLES - 1));
    assign w_geom_valid = (r_state != S_IDLE) && (r_state != S_LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_FILL;
            S_FILL:  if (w_fill_last) w_state_nxt = (w_digit == 4'd0) ? S_NEXT : S_GCLR;
            S_GCLR:  w_state_nxt = S_GLYPH;
            S_GLYPH: if (w_glyph_last) w_state_nxt = S_NEXT;
            S_NEXT:  w_state_nxt = (r_tile == 4'd15) ? S_DONE : S_FILL;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Board latch, tile index, fill raster and glyph budget counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_board <= '0;
            r_tile  <= '0;
            r_fx    <= '0;
            r_fy    <= '0;
            r_gcnt  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_board <= board;
                    r_tile  <= '0;
                    r_fx    <= '0;
                    r_fy    <= '0;
                    r_gcnt  <= '0;
                end
                S_FILL: begin
                    if (r_fx == FW'(TILE_SIZE - 1)) begin
                        r_fx <= '0;
                        r_fy <= (r_fy == FW'(TILE_SIZE - 1)) ? '0 : r_fy + FW'(1);
                    end else begin
                        r_fx <= r_fx + FW'(1);
                    end
                end
                S_GLYPH: r_gcnt <= w_glyph_last ? '0 : r_gcnt + GW'(1);
                S_NEXT:  if (r_tile != 4'd15) r_tile <= r_tile + 4'd1;
                S_DONE:  r_tile <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        glyph_clear  = 1'b0;
        glyph_enable = 1'b0;
        plot         = 1'b0;
        x            = '0;
        y            = '0;
        colour       = '0;
        tile_x       = w_geom_valid ? w_tile_x : '0;
        tile_y       = w_geom_valid ? w_tile_y : '0;
        digit        = w_geom_valid ? w_digit  : '0;
        case (r_state)
            S_FILL: begin
                plot   = 1'b1;
                x      = w_fill_x;
                y      = w_fill_y;
                colour = (w_digit == 4'd0) ? BG_COLOUR : TILE_COLOUR;
            end
            S_GCLR:  glyph_clear = 1'b1;
            S_GLYPH: begin
                glyph_enable = 1'b1;
                plot         = 1'b1;
                x            = glyph_x;
                y            = glyph_y;
                colour       = DIGIT_COLOUR;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_board_draw_scheduler.sv
// Scoreboard bench for board_draw_scheduler: expected plots and redraw
// completions are queued at start; a monitor pops them as the DUT emits them.
module tb_board_draw_scheduler;

    localparam int TS = 30;
    localparam int GC = 121;
    localparam int OX = 16;
    localparam int OY = 0;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        logic [7:0] tile_x;
        logic [6:0] tile_y;
        logic [3:0] digit;
    } plot_t;

    typedef struct packed {
        logic [31:0] busy_cyc;
        logic [31:0] gclr;
        logic [31:0] gen;
    } done_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] board;
    logic [7:0]  glyph_x;
    logic [6:0]  glyph_y;
    logic        busy;
    logic        done;
    logic [7:0]  tile_x;
    logic [6:0]  tile_y;
    logic [3:0]  digit;
    logic        glyph_clear;
    logic        glyph_enable;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;

    plot_t exp_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;
    int    busy_cyc = 0;
    int    gclr_cnt = 0;
    int    gen_cnt = 0;

    board_draw_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .board(board),
        .glyph_x(glyph_x), .glyph_y(glyph_y), .busy(busy), .done(done),
        .tile_x(tile_x), .tile_y(tile_y), .digit(digit),
        .glyph_clear(glyph_clear), .glyph_enable(glyph_enable),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference plot stream and completion record for one redraw of board b
    function automatic void push_expected(input logic [63:0] b);
        done_t d;
        plot_t p;
        logic [3:0] v;
        logic [7:0] tx;
        logic [6:0] ty;
        int nz;
        int total;
        nz = 0;
        total = 2;
        for (int t = 0; t < 16; t++) begin
            v  = b[4*t +: 4];
            tx = 8'(OX + (t % 4) * TS);
            ty = 7'(OY + (t / 4) * TS);
            for (int fy = 0; fy < TS; fy++) begin
                for (int fx = 0; fx < TS; fx++) begin
                    p.x = 8'(tx + fx);
                    p.y = 7'(ty + fy);
                    p.colour = (v == 4'd0) ? 3'b000 : 3'b111;
                    p.tile_x = tx;
                    p.tile_y = ty;
                    p.digit = v;
                    exp_q.push_back(p);
                end
            end
            if (v != 4'd0) begin
                nz++;
                for (int g = 0; g < GC; g++) begin
                    p.x = glyph_x;
                    p.y = glyph_y;
                    p.colour = 3'b000;
                    p.tile_x = tx;
                    p.tile_y = ty;
                    p.digit = v;
                    exp_q.push_back(p);
                end
                total += TS * TS + GC + 2;
            end else begin
                total += TS * TS + 1;
            end
        end
        d.busy_cyc = 32'(total);
        d.gclr = 32'(nz);
        d.gen = 32'(nz * GC);
        done_q.push_back(d);
    endfunction

    // Monitor: pops and compares whenever the DUT plots or signals done
    initial begin
        plot_t e;
        plot_t a;
        done_t de;
        done_t da;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                busy_cyc = 0;
                gclr_cnt = 0;
                gen_cnt = 0;
            end else begin
                if (busy) busy_cyc++;
                if (glyph_enable) gen_cnt++;
                if (glyph_clear) begin
                    gclr_cnt++;
                    check("gclr_plot", 64'(plot), 64'd0);
                end
                if (plot) begin
                    a.x = x; a.y = y; a.colour = colour;
                    a.tile_x = tile_x; a.tile_y = tile_y; a.digit = digit;
                    if (exp_q.size() == 0) begin
                        check("plot_unexpected", 64'(a), 64'd0 - 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("plot", 64'(a), 64'(e));
                    end
                end
                if (done) begin
                    da.busy_cyc = 32'(busy_cyc);
                    da.gclr = 32'(gclr_cnt);
                    da.gen = 32'(gen_cnt);
                    if (done_q.size() == 0) begin
                        check("done_unexpected", 64'(done), 64'd0);
                    end else begin
                        de = done_q.pop_front();
                        check("busy_cycles", 64'(da.busy_cyc), 64'(de.busy_cyc));
                        check("gclr_pulses", 64'(da.gclr), 64'(de.gclr));
                        check("genable_cycles", 64'(da.gen), 64'(de.gen));
                    end
                    busy_cyc = 0;
                    gclr_cnt = 0;
                    gen_cnt = 0;
                    done_cnt++;
                end
            end
        end
    end

    // One redraw; optional board disturbance, ignored restart, or abort by reset
    task automatic redraw(input logic [63:0] b, input int reset_at, input bit disturb);
        int d0;
        bit aborted;
        aborted = 1'b0;
        @(negedge clk);
        board = b;
        start = 1'b1;
        push_expected(b);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 20000 && done_cnt == d0; c++) begin
            if (disturb && c == 10) board = '0;
            if (disturb && c == 500) start = 1'b1;
            if (disturb && c == 501) start = 1'b0;
            if (c == reset_at) begin
                reset = 1'b1;
                exp_q.delete();
                done_q.delete();
                @(posedge clk);
                #1;
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_plot", 64'(plot), 64'd0);
                check("abort_genable", 64'(glyph_enable), 64'd0);
                @(negedge clk);
                reset = 1'b0;
                repeat (5) @(negedge clk);
                check("abort_no_done", 64'(done_cnt), 64'(d0));
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!aborted) begin
            check("redraw_completed", 64'(done_cnt - d0), 64'd1);
            @(negedge clk);
            check("busy_after_done", 64'(busy), 64'd0);
            check("plots_left", 64'(exp_q.size()), 64'd0);
            repeat (20) @(negedge clk);
            check("single_done", 64'(done_cnt - d0), 64'd1);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        board = 64'h0FED_CBA9_8765_4321;
        glyph_x = 8'hAB;
        glyph_y = 7'h55;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            check("idle_outs", {busy, plot, done, glyph_clear, glyph_enable, x, y, colour},
                  64'd0);
            if (c == 0) check("idle_geom", {tile_x, tile_y, digit}, 64'd0);
        end
        redraw(64'h0FED_CBA9_8765_4321, -1, 1'b1);
        redraw(64'h0FED_CBA9_8765_4321, 3000, 1'b0);
        redraw(64'h0FED_CBA9_8765_4321, -1, 1'b0);
        redraw(64'h3000_50A0_0C01_E020, -1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/board_draw_scheduler.md
Name: board_draw_scheduler

Overview:
Sequences redraw of the 4x4 sliding-puzzle board onto the VGA plot interface. On start it latches the board state and walks tiles 0..15. For each tile it raster-fills the tile square, then runs the shared digit-glyph drawer for a fixed cycle budget at that tile's origin. It is the only block driving the plotter during a redraw, and it muxes its own fill coordinates with the glyph drawer's coordinates.

Parameters:
ORIGIN_X, 8'd16, x pixel of tile 0 top-left
ORIGIN_Y, 7'd0, y pixel of tile 0 top-left
TILE_SIZE, 30, tile edge in pixels (grid pitch = TILE_SIZE)
GLYPH_CYCLES, 121, cycles the glyph drawer needs to complete one digit
TILE_COLOUR, 3'b111, fill colour for numbered tiles
BG_COLOUR, 3'b000, fill colour for the blank tile
DIGIT_COLOUR, 3'b000, colour during glyph plotting

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
start  in  1  request a redraw; sampled only in IDLE
board  in  64  tile i value at board[4i+3:4i]; 0 = blank, 1..15 = number
glyph_x  in  8  pixel x from the glyph drawer (already offset by tile_x)
glyph_y  in  7  pixel y from the glyph drawer
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the redraw completes
tile_x  out  8  origin x of the current tile, fed to the glyph drawer xIn
tile_y  out  7  origin y of the current tile, fed to the glyph drawer yIn
digit  out  4  latched value of the current tile, which selects the glyph
glyph_clear  out  1  one-cycle reset pulse to the glyph drawer
glyph_enable  out  1  enable to the glyph drawer
x  out  8  plot x
y  out  7  plot y
colour  out  3  plot colour
plot  out  1  write strobe to the VGA adapter

Behaviour:
- Reset (any state, any cycle): go to IDLE. All outputs 0. Tile index, fill counters and glyph counter are 0. Latched board is cleared. A redraw in progress is abandoned, and no done pulse is produced.
- IDLE: if start=1, go to LOAD. Otherwise hold. A start while busy is ignored and is not queued.
- LOAD (1 cycle): latch board into an internal register, set tile=0, then go to FILL. Changes on the board input after LOAD do not affect this redraw.
- Tile geometry: col=tile[1:0], row=tile[3:2]. tile_x=ORIGIN_X+col*TILE_SIZE. tile_y=ORIGIN_Y+row*TILE_SIZE. Both are computed at full width and truncated to port width; defaults never overflow. digit=latched value of the current tile.
- FILL: runs TILE_SIZE*TILE_SIZE cycles with plot=1.
  - fx advances 0..TILE_SIZE-1 every cycle. fy increments when fx wraps.
  - x=tile_x+fx, y=tile_y+fy.
  - colour=BG_COLOUR if digit==0, else TILE_COLOUR.
  - After the cycle with fx=fy=TILE_SIZE-1: go to NEXT if digit==0, else go to GCLR.
- GCLR (1 cycle): glyph_clear=1, plot=0, then go to GLYPH.
- GLYPH: runs exactly GLYPH_CYCLES cycles with glyph_enable=1 and plot=1. In this state x=glyph_x, y=glyph_y, colour=DIGIT_COLOUR. Then go to NEXT.
- NEXT (1 cycle): plot=0. If tile==15, go to DONE. Otherwise tile+1 and go to FILL.
- DONE (1 cycle): done=1, busy=1, then go to IDLE.
- Outside the listed states, glyph_enable, glyph_clear, plot and done are 0. x, y and colour are don't-care when plot=0; drive them 0.
- Cycle budget:
  - Numbered tile: TILE_SIZE²+GLYPH_CYCLES+2 cycles (1023 at defaults).
  - Blank tile: TILE_SIZE²+1 cycles (901 at defaults).
  - busy is high for 1 (LOAD) + sum over tiles + 1 (DONE) cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from start or board to any output.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, start=0 -> busy=0, plot=0, done=0, x=y=0 for 50 cycles.
- Solved board: board={4'h0,4'hF,...,4'h1} (tile i=i+1, tile 15 blank), pulse start -> busy high for exactly 16248 cycles, done high only on the last one. Exactly 15 glyph_clear pulses. glyph_enable high for 15*121=1815 cycles total.
- Tile geometry: same board -> first FILL plot is (16,0) colour 111. First plot of tile 5 is (46,30). Last FILL plot of tile 15 is (135,119) colour 000. During tile 6 GLYPH, digit=7 and tile_x=76, tile_y=30.
- Glyph mux: drive glyph_x=8'hAB, glyph_y=7'h55 during GLYPH -> x=8'hAB, y=7'h55, colour=DIGIT_COLOUR, plot=1. In GCLR and NEXT, plot=0.
- Start ignored / board latched: pulse start again at cycle 500 and change board to all-zero at cycle 10 -> redraw still uses the original values, takes 16248 cycles, and produces exactly one done.
- Reset mid-operation: assert reset at cycle 3000 -> next cycle busy=0, plot=0, glyph_enable=0, no done. A following start gives a full 16248-cycle redraw from tile 0.
